// File: rtl/console_in_buffer_pkg.sv
// Shared constants and types for the console receive buffer.
package console_in_buffer_pkg;

  // Default character width.
  localparam int DEF_DATA_W = 8;

  // End-of-line codes: carriage return is the default line terminator.
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Handshake FSM: idle, offering a character, holding while acked, one-cycle gap.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } con_state_e;

endpackage

// File: rtl/console_in_buffer_if.sv
// UART strobe input plus the Wrapper CONSOLE_IN valid/ack handshake.
interface console_in_buffer_if
  import console_in_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_VALID;
  logic [DATA_W-1:0] CONSOLE_IN;
  logic              CONSOLE_IN_valid;
  logic              CONSOLE_IN_ack;

  // Environment side: UART receiver and the consuming processor.
  modport master (
    output RX_DATA, RX_VALID, CONSOLE_IN_ack,
    input  CONSOLE_IN, CONSOLE_IN_valid
  );

  // Buffer side.
  modport slave (
    input  RX_DATA, RX_VALID, CONSOLE_IN_ack,
    output CONSOLE_IN, CONSOLE_IN_valid
  );
endinterface

// File: rtl/console_in_buffer_sync_fifo.sv
// Synchronous FIFO with flush; head entry is read combinationally and the
// occupancy/full/empty flags are registered.
module sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              push_ok_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q;
  logic              wr_en_s, rd_en_s;

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign wr_en_s   = push_i && (!full_q || pop_i) && !flush_i;
  assign rd_en_s   = pop_i && !empty_q && !flush_i;
  assign push_ok_o = wr_en_s;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

  // Next occupancy from the push/pop pair; flush empties the FIFO.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({wr_en_s, rd_en_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; flags follow count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en_s) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (rd_en_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == CW'(0));
    end
  end

endmodule

// File: rtl/console_in_buffer.sv
// Receive-side console buffer: queues UART characters and offers them one at
// a time over the Wrapper's 4-phase valid/ack handshake, optionally only once
// a whole line has arrived.
module console_in_buffer
  import console_in_buffer_pkg::*;
#(
  parameter  int                DATA_W    = DEF_DATA_W,
  parameter  int                DEPTH     = 16,
  parameter  int                LINE_MODE = 0,
  parameter  logic [DATA_W-1:0] EOL_CHAR  = DATA_W'(CHAR_CR),
  localparam int                CW        = $clog2(DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 FLUSH,
  console_in_buffer_if.slave   bus,
  output logic [CW-1:0]        COUNT,
  output logic [CW-1:0]        LINES,
  output logic                 FULL,
  output logic                 EMPTY,
  output logic                 OVERFLOW
);

  con_state_e        state_q;
  logic [DATA_W-1:0] con_data_q;
  logic              con_valid_q;
  logic [CW-1:0]     lines_q, lines_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] head_s;
  logic              push_ok_s, pop_s, rel_s;
  logic              eol_in_s, eol_out_s;

  // The head leaves only on the first acked cycle of an offer, never during flush.
  assign pop_s     = (state_q == ST_OFFER) && bus.CONSOLE_IN_ack && !FLUSH;
  assign eol_in_s  = push_ok_s && (bus.RX_DATA == EOL_CHAR);
  assign eol_out_s = pop_s && (head_s == EOL_CHAR);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_ni    (RESETn),
    .push_i    (bus.RX_VALID),
    .pop_i     (pop_s),
    .flush_i   (FLUSH),
    .data_i    (bus.RX_DATA),
    .head_o    (head_s),
    .count_o   (COUNT),
    .full_o    (FULL),
    .empty_o   (EMPTY),
    .push_ok_o (push_ok_s)
  );

  // Release rule: any data, or in line mode a full line (or a full buffer to avoid deadlock).
  always_comb begin
    rel_s = 1'b0;
    if (LINE_MODE != 0) begin
      rel_s = (lines_q != CW'(0)) || FULL;
    end else begin
      rel_s = !EMPTY;
    end
  end

  // Line counter follows EOL characters entering and leaving; overflow is sticky until flush.
  always_comb begin
    lines_d    = lines_q;
    overflow_d = overflow_q;
    if (FLUSH) begin
      lines_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case ({eol_in_s, eol_out_s})
        2'b10:   lines_d = lines_q + CW'(1);
        2'b01:   lines_d = lines_q - CW'(1);
        default: lines_d = lines_q;
      endcase
      if (bus.RX_VALID && !push_ok_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Line and overflow status registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      lines_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      lines_q    <= lines_d;
      overflow_q <= overflow_d;
    end
  end

  // Handshake FSM; a flush during an acked offer waits for ack to fall with valid forced low.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      con_valid_q <= 1'b0;
      con_data_q  <= '0;
    end else if (FLUSH) begin
      con_valid_q <= 1'b0;
      if (((state_q == ST_OFFER) || (state_q == ST_HOLD)) && bus.CONSOLE_IN_ack) begin
        state_q <= ST_HOLD;
      end else begin
        state_q <= ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rel_s) begin
            con_data_q  <= head_s;
            con_valid_q <= 1'b1;
            state_q     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (bus.CONSOLE_IN_ack) state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!bus.CONSOLE_IN_ack) begin
            con_valid_q <= 1'b0;
            state_q     <= ST_GAP;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          con_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.CONSOLE_IN       = con_data_q;
  assign bus.CONSOLE_IN_valid = con_valid_q;
  assign LINES                = lines_q;
  assign OVERFLOW             = overflow_q;

endmodule

// File: tb/tb_console_in_buffer.sv
// Bench for console_in_buffer: one instance in direct mode (u0) and one in
// line mode (u1), checked every cycle against a queue-level reference model.
module tb_console_in_buffer;

  localparam int DEPTH = 16;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       rxv [2];
  logic [7:0] rxd [2];
  logic       flv [2];
  logic       ack [2];

  logic [4:0] ocount [2];
  logic [4:0] olines [2];
  logic       ofull [2];
  logic       oempty [2];
  logic       oovf [2];
  logic       ovalid [2];
  logic [7:0] odata [2];

  int n_vec = 0;
  int n_err = 0;

  console_in_buffer_if #(.DATA_W(8)) bus0 ();
  console_in_buffer_if #(.DATA_W(8)) bus1 ();

  assign bus0.RX_VALID       = rxv[0];
  assign bus0.RX_DATA        = rxd[0];
  assign bus0.CONSOLE_IN_ack = ack[0];
  assign bus1.RX_VALID       = rxv[1];
  assign bus1.RX_DATA        = rxd[1];
  assign bus1.CONSOLE_IN_ack = ack[1];
  assign ovalid[0] = bus0.CONSOLE_IN_valid;
  assign odata[0]  = bus0.CONSOLE_IN;
  assign ovalid[1] = bus1.CONSOLE_IN_valid;
  assign odata[1]  = bus1.CONSOLE_IN;

  console_in_buffer #(.DATA_W(8), .DEPTH(DEPTH), .LINE_MODE(0), .EOL_CHAR(8'h0D)) u0 (
    .CLK(CLK), .RESETn(RESETn), .FLUSH(flv[0]), .bus(bus0),
    .COUNT(ocount[0]), .LINES(olines[0]), .FULL(ofull[0]), .EMPTY(oempty[0]), .OVERFLOW(oovf[0])
  );

  console_in_buffer #(.DATA_W(8), .DEPTH(DEPTH), .LINE_MODE(1), .EOL_CHAR(8'h0D)) u1 (
    .CLK(CLK), .RESETn(RESETn), .FLUSH(flv[1]), .bus(bus1),
    .COUNT(ocount[1]), .LINES(olines[1]), .FULL(ofull[1]), .EMPTY(oempty[1]), .OVERFLOW(oovf[1])
  );

  always #5 CLK = ~CLK;

  // Reference model: a plain array kept front-aligned, plus handshake phase.
  // Phase: 0 waiting, 1 offering, 2 acked, 3 one-cycle gap.
  logic [7:0] mbuf [2][DEPTH];
  int         msize [2];
  bit         movf [2];
  int         mph [2];
  bit         mvis [2];
  logic [7:0] mdata [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eol_cnt(input int i);
    int n = 0;
    for (int k = 0; k < msize[i]; k++) if (mbuf[i][k] == 8'h0D) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      msize[i] = 0; movf[i] = 1'b0; mph[i] = 0; mvis[i] = 1'b0; mdata[i] = 8'h00;
    end
  endtask

  task automatic model_step(input int i);
    bit full  = (msize[i] == DEPTH);
    bit empty = (msize[i] == 0);
    bit rel   = (i == 1) ? ((eol_cnt(i) > 0) || full) : !empty;
    bit pop   = (mph[i] == 1) && ack[i] && !flv[i];
    logic [7:0] head = mbuf[i][0];
    bit pushok;
    if (flv[i]) begin
      msize[i] = 0;
      movf[i]  = 1'b0;
      mvis[i]  = 1'b0;
      mph[i]   = (((mph[i] == 1) || (mph[i] == 2)) && ack[i]) ? 2 : 0;
    end else begin
      pushok = rxv[i] && (!full || pop);
      if (pop) begin
        for (int k = 0; k < DEPTH - 1; k++) mbuf[i][k] = mbuf[i][k+1];
        msize[i]--;
      end
      if (pushok) begin
        mbuf[i][msize[i]] = rxd[i];
        msize[i]++;
      end else if (rxv[i]) begin
        movf[i] = 1'b1;
      end
      case (mph[i])
        0: if (rel) begin mph[i] = 1; mvis[i] = 1'b1; mdata[i] = head; end
        1: if (ack[i]) mph[i] = 2;
        2: if (!ack[i]) begin mph[i] = 3; mvis[i] = 1'b0; end
        default: mph[i] = 0;
      endcase
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.count", i), 32'(ocount[i]), 32'(msize[i]));
      check_eq($sformatf("u%0d.lines", i), 32'(olines[i]), 32'(eol_cnt(i)));
      check_eq($sformatf("u%0d.full", i), 32'(ofull[i]), 32'(msize[i] == DEPTH));
      check_eq($sformatf("u%0d.empty", i), 32'(oempty[i]), 32'(msize[i] == 0));
      check_eq($sformatf("u%0d.overflow", i), 32'(oovf[i]), 32'(movf[i]));
      check_eq($sformatf("u%0d.valid", i), 32'(ovalid[i]), 32'(mvis[i]));
      check_eq($sformatf("u%0d.data", i), 32'(odata[i]), 32'(mdata[i]));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic strobe(input int i, input logic [7:0] c);
    rxv[i] = 1'b1; rxd[i] = c;
    tick();
    rxv[i] = 1'b0;
  endtask

  // Wait (bounded) for an offer, check its character, ack for 'hold' cycles, release.
  task automatic consume(input int i, input logic [7:0] exp, input int hold);
    int t = 0;
    while (!ovalid[i] && t < 40) begin tick(); t++; end
    check_eq($sformatf("u%0d.offer_seen", i), 32'(ovalid[i]), 32'd1);
    check_eq($sformatf("u%0d.offer_char", i), 32'(odata[i]), 32'(exp));
    ack[i] = 1'b1;
    repeat (hold) tick();
    ack[i] = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rxv[i] = 1'b0; rxd[i] = 8'h00; flv[i] = 1'b0; ack[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    RESETn = 1'b1;
    tick();

    // Direct mode latency and a 3-cycle ack yields exactly one pop.
    strobe(0, 8'h50);
    check_eq("lat.edge1", 32'(ovalid[0]), 32'd0);
    tick();
    check_eq("lat.edge2", 32'(ovalid[0]), 32'd1);
    check_eq("lat.char", 32'(odata[0]), 32'h50);
    ack[0] = 1'b1;
    repeat (3) tick();
    check_eq("ack3.count", 32'(ocount[0]), 32'd0);
    ack[0] = 1'b0;
    tick();
    check_eq("gap.valid", 32'(ovalid[0]), 32'd0);
    repeat (3) tick();

    // Line mode holds characters until the EOL arrives.
    strobe(1, 8'h50);
    strobe(1, 8'h41);
    repeat (4) tick();
    check_eq("line.held", 32'(ovalid[1]), 32'd0);
    check_eq("line.count2", 32'(ocount[1]), 32'd2);
    strobe(1, 8'h0D);
    check_eq("line.lines1", 32'(olines[1]), 32'd1);
    consume(1, 8'h50, 1);
    consume(1, 8'h41, 2);
    consume(1, 8'h0D, 1);
    check_eq("line.lines0", 32'(olines[1]), 32'd0);
    repeat (3) tick();

    // Fill past DEPTH with the consumer idle; 0x10 is dropped.
    for (int c = 0; c <= 16; c++) strobe(0, 8'(c));
    tick();
    check_eq("fill.full", 32'(ofull[0]), 32'd1);
    check_eq("fill.ovf", 32'(oovf[0]), 32'd1);
    for (int c = 0; c < 16; c++) consume(0, 8'(c), 1 + (c % 3));
    check_eq("drain.empty", 32'(oempty[0]), 32'd1);
    flv[0] = 1'b1; tick(); flv[0] = 1'b0;
    check_eq("flush.ovf", 32'(oovf[0]), 32'd0);
    tick();

    // Line mode, full with no EOL: forced release, push during the pop is kept.
    for (int c = 0; c < 16; c++) strobe(1, 8'(8'h20 + c));
    while (!ovalid[1]) tick();
    check_eq("lfull.char", 32'(odata[1]), 32'h20);
    ack[1] = 1'b1; rxv[1] = 1'b1; rxd[1] = 8'h5A;
    tick();
    rxv[1] = 1'b0;
    check_eq("lfull.count", 32'(ocount[1]), 32'd16);
    check_eq("lfull.noovf", 32'(oovf[1]), 32'd0);
    tick(); ack[1] = 1'b0; tick();
    consume(1, 8'h21, 1);
    repeat (8) tick();
    check_eq("lfull.stall", 32'(ovalid[1]), 32'd0);
    flv[1] = 1'b1; tick(); flv[1] = 1'b0; tick();

    // Flush while acked in HOLD with 5 entries left.
    for (int c = 0; c < 6; c++) strobe(0, 8'(8'h61 + c));
    while (!ovalid[0]) tick();
    ack[0] = 1'b1;
    tick();
    check_eq("fhold.count5", 32'(ocount[0]), 32'd5);
    flv[0] = 1'b1; tick(); flv[0] = 1'b0;
    check_eq("fhold.valid", 32'(ovalid[0]), 32'd0);
    check_eq("fhold.count", 32'(ocount[0]), 32'd0);
    strobe(0, 8'h77);
    tick();
    check_eq("fhold.wait", 32'(ovalid[0]), 32'd0);
    ack[0] = 1'b0;
    tick();
    tick();
    check_eq("fhold.gap", 32'(ovalid[0]), 32'd0);
    tick();
    check_eq("fhold.reoffer", 32'(ovalid[0]), 32'd1);
    check_eq("fhold.char", 32'(odata[0]), 32'h77);
    consume(0, 8'h77, 1);
    tick();

    // Asynchronous reset in the middle of an offer.
    strobe(0, 8'h42);
    while (!ovalid[0]) tick();
    #2 RESETn = 1'b0;
    #1;
    model_reset();
    check_eq("rst.valid", 32'(ovalid[0]), 32'd0);
    check_all();
    @(posedge CLK);
    #1 RESETn = 1'b1;
    check_eq("rst.empty", 32'(oempty[0]), 32'd1);
    tick();

    // Random traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        rxv[i] = ($urandom_range(0, 2) == 0);
        rxd[i] = ($urandom_range(0, 4) == 0) ? 8'h0D : 8'($urandom);
        flv[i] = ($urandom_range(0, 99) == 0);
        ack[i] = ($urandom_range(0, 1) == 1);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
